// File: rtl/sprite_engine_if.sv
// Bundle between the sprite engine and its surroundings: the VGA timing side
// (pixel position, display, background, frame tick, move requests), the
// external registered sprite ROM, and the resolved colour/collision outputs.
//   master : environment (timing generator, controls, ROM)
//   slave  : sprite_engine
interface sprite_engine_if #(
   parameter int NUM_SPRITES = 2,
   parameter int SPRITE_W    = 16,
   parameter int SPRITE_H    = 16,
   parameter int COLOR_W     = 12
);
   localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
   localparam int AW = $clog2(SPRITE_W * SPRITE_H);

   logic                   frame_tick;
   logic                   display;
   logic [9:0]             hrow;
   logic [9:0]             vcolumn;
   logic [COLOR_W-1:0]     background;
   logic [NUM_SPRITES-1:0] up;
   logic [NUM_SPRITES-1:0] down;
   logic [NUM_SPRITES-1:0] left;
   logic [NUM_SPRITES-1:0] right;
   logic [IW+AW-1:0]       rom_addr;
   logic [COLOR_W-1:0]     rom_data;
   logic [COLOR_W-1:0]     pix_color;
   logic                   pix_valid;
   logic [NUM_SPRITES-1:0] collision;

   modport master (
      output frame_tick, display, hrow, vcolumn, background,
      output up, down, left, right, rom_data,
      input  rom_addr, pix_color, pix_valid, collision
   );

   modport slave (
      input  frame_tick, display, hrow, vcolumn, background,
      input  up, down, left, right, rom_data,
      output rom_addr, pix_color, pix_valid, collision
   );
endinterface

// File: rtl/sprite_engine.sv
// Multi-sprite overlay for the VGA path.
// Tracks NUM_SPRITES movable sprites (clamped to the visible area), picks the
// highest-priority (lowest index) sprite under the current pixel, fetches its
// texel from an external registered ROM and resolves transparency against the
// background with a fixed two-clock latency. Reports per-frame overlaps.
// Ports:
//   inputclk : pixel clock
//   reset    : asynchronous, active-high
//   bus      : sprite_engine_if.slave (timing inputs, move requests, ROM, outputs)
module sprite_engine #(
   parameter int                 NUM_SPRITES = 2,
   parameter int                 SPRITE_W    = 16,
   parameter int                 SPRITE_H    = 16,
   parameter int                 H_ACTIVE    = 640,
   parameter int                 V_ACTIVE    = 480,
   parameter int                 COLOR_W     = 12,
   parameter int                 STEP        = 1,
   parameter logic [COLOR_W-1:0] TRANSPARENT = '0
) (
   input logic            inputclk,
   input logic            reset,
   sprite_engine_if.slave bus
);
   localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
   localparam int AW = $clog2(SPRITE_W * SPRITE_H);
   localparam int WB = $clog2(SPRITE_W);
   localparam int HB = $clog2(SPRITE_H);

   localparam logic [10:0] HMAX   = 11'(H_ACTIVE - SPRITE_W);
   localparam logic [10:0] VMAX   = 11'(V_ACTIVE - SPRITE_H);
   localparam logic [10:0] STEP_V = 11'(STEP);

   logic [10:0]            x_pos [NUM_SPRITES];
   logic [10:0]            y_pos [NUM_SPRITES];
   logic [NUM_SPRITES-1:0] hit;
   logic [NUM_SPRITES-1:0] coll_acc;
   logic [IW-1:0]          win_idx;
   logic [AW-1:0]          win_addr;
   logic [3:0]             hit_cnt;
   logic                   hit_any;
   logic                   multi_hit;

   logic                   hit_q1, hit_q2;
   logic                   disp_q1, disp_q2;
   logic [COLOR_W-1:0]     bg_q1, bg_q2;

   function automatic logic [10:0] x_init(int i);
      return (i * 2 * SPRITE_W > H_ACTIVE - SPRITE_W) ? HMAX : 11'(i * 2 * SPRITE_W);
   endfunction

   // Saturating move; written so p + STEP is only formed when it cannot pass pmax.
   function automatic logic [10:0] step_pos(logic [10:0] p, logic inc, logic dec,
                                            logic [10:0] pmax);
      logic [10:0] n;
      n = p;
      if (inc && !dec)
         n = (pmax - p <= STEP_V) ? pmax : p + STEP_V;
      else if (dec && !inc)
         n = (p <= STEP_V) ? '0 : p - STEP_V;
      return n;
   endfunction

   // Unsigned differences: a pixel left of / above the sprite wraps to a large
   // value and falls out of range. Iterating downward lets the lowest index win.
   always_comb begin
      logic [10:0] ddx;
      logic [10:0] ddy;
      ddx      = '0;
      ddy      = '0;
      hit      = '0;
      win_idx  = '0;
      win_addr = '0;
      hit_cnt  = '0;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         ddx    = {1'b0, bus.hrow} - x_pos[i];
         ddy    = {1'b0, bus.vcolumn} - y_pos[i];
         hit[i] = bus.display && (ddx < 11'(SPRITE_W)) && (ddy < 11'(SPRITE_H));
         if (hit[i]) begin
            win_idx  = IW'(i);
            win_addr = {ddy[HB-1:0], ddx[WB-1:0]};
            hit_cnt  = hit_cnt + 4'd1;
         end
      end
   end

   assign hit_any   = |hit;
   assign multi_hit = (hit_cnt >= 4'd2);

   always_ff @(posedge inputclk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            x_pos[i] <= x_init(i);
            y_pos[i] <= '0;
         end
      end else if (bus.frame_tick) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            x_pos[i] <= step_pos(x_pos[i], bus.right[i], bus.left[i], HMAX);
            y_pos[i] <= step_pos(y_pos[i], bus.down[i], bus.up[i], VMAX);
         end
      end
   end

   // The frame_tick cycle's own overlap is folded into the reported value.
   always_ff @(posedge inputclk or posedge reset) begin
      if (reset) begin
         coll_acc      <= '0;
         bus.collision <= '0;
      end else if (bus.frame_tick) begin
         bus.collision <= coll_acc | (multi_hit ? hit : '0);
         coll_acc      <= '0;
      end else if (multi_hit) begin
         coll_acc <= coll_acc | hit;
      end
   end

   // Side-band (hit/display/background) rides two stages to meet the ROM
   // data, which arrives one clock after rom_addr is registered.
   always_ff @(posedge inputclk or posedge reset) begin
      if (reset) begin
         bus.rom_addr  <= '0;
         hit_q1        <= 1'b0;
         hit_q2        <= 1'b0;
         disp_q1       <= 1'b0;
         disp_q2       <= 1'b0;
         bg_q1         <= '0;
         bg_q2         <= '0;
         bus.pix_color <= '0;
         bus.pix_valid <= 1'b0;
      end else begin
         if (hit_any)
            bus.rom_addr <= {win_idx, win_addr};
         hit_q1        <= hit_any;
         disp_q1       <= bus.display;
         bg_q1         <= bus.background;
         hit_q2        <= hit_q1;
         disp_q2       <= disp_q1;
         bg_q2         <= bg_q1;
         bus.pix_valid <= disp_q2;
         if (!disp_q2)
            bus.pix_color <= '0;
         else if (hit_q2 && (bus.rom_data != TRANSPARENT))
            bus.pix_color <= bus.rom_data;
         else
            bus.pix_color <= bg_q2;
      end
   end
endmodule

// File: tb/tb_sprite_engine.sv
// Bench for sprite_engine (2 sprites, 16x16, 640x480, 12-bit colour).
// A behavioural model (positions as integers, winner by search, output as a
// two-deep delay queue) is compared against the DUT every clock, and a set of
// hand-computed literal values pins both the model and the DUT.
module tb_sprite_engine;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sprite_engine_if #(.NUM_SPRITES(2), .SPRITE_W(16), .SPRITE_H(16), .COLOR_W(12)) bus();

   sprite_engine dut (
      .inputclk (clk),
      .reset    (rst),
      .bus      (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [11:0] rom_fixed [2];
   bit          rom_fix_en [2];

   // Model state
   int mx [2];
   int my [2];
   int m_acc, m_coll, m_addr, cur_exp;
   int exp_q [$];

   function automatic int rom_val(int s, int a);
      if (rom_fix_en[s]) return int'(rom_fixed[s]);
      return ((s + 1) << 8) | (a & 255);
   endfunction

   // Registered sprite ROM
   always @(posedge clk)
      bus.rom_data <= 12'(rom_val(int'(bus.rom_addr[8]), int'(bus.rom_addr[7:0])));

   task automatic chk(string name, int act, int expv);
      n_cmp++;
      if (act != expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mx[i] = i * 32;
         my[i] = 0;
      end
      m_acc   = 0;
      m_coll  = 0;
      m_addr  = 0;
      cur_exp = 0;
      exp_q   = '{0, 0};
   endtask

   task automatic model_step();
      int mask, cnt, w, wdx, wdy, dx, dy, col, texel;
      mask = 0; cnt = 0; w = -1; wdx = 0; wdy = 0;
      for (int i = 0; i < 2; i++) begin
         dx = int'(bus.hrow) - mx[i];
         dy = int'(bus.vcolumn) - my[i];
         if (bus.display && dx >= 0 && dx < 16 && dy >= 0 && dy < 16) begin
            mask |= (1 << i);
            cnt++;
            if (w < 0) begin w = i; wdx = dx; wdy = dy; end
         end
      end
      if (w >= 0) m_addr = w * 256 + wdy * 16 + wdx;
      col = 0;
      if (bus.display) begin
         col = int'(bus.background);
         if (w >= 0) begin
            texel = rom_val(w, wdy * 16 + wdx);
            if (texel != 0) col = texel;
         end
      end
      exp_q.push_back(((bus.display ? 1 : 0) << 12) | col);
      cur_exp = exp_q.pop_front();
      if (bus.frame_tick) begin
         m_coll = m_acc | ((cnt >= 2) ? mask : 0);
         m_acc  = 0;
         for (int i = 0; i < 2; i++) begin
            if (bus.right[i] && !bus.left[i]) mx[i] = (mx[i] + 1 > 624) ? 624 : mx[i] + 1;
            if (bus.left[i] && !bus.right[i]) mx[i] = (mx[i] - 1 < 0) ? 0 : mx[i] - 1;
            if (bus.down[i] && !bus.up[i])    my[i] = (my[i] + 1 > 464) ? 464 : my[i] + 1;
            if (bus.up[i] && !bus.down[i])    my[i] = (my[i] - 1 < 0) ? 0 : my[i] - 1;
         end
      end else if (cnt >= 2) begin
         m_acc |= mask;
      end
   endtask

   // Per-cycle compare, 1 ns after the active edge
   always @(posedge clk) begin
      if (rst) model_reset();
      else model_step();
      #1;
      chk("pix_valid", int'(bus.pix_valid), cur_exp >> 12);
      chk("pix_color", int'(bus.pix_color), cur_exp & 12'hFFF);
      chk("collision", int'(bus.collision), m_coll);
      chk("rom_addr", int'(bus.rom_addr), m_addr);
   end

   task automatic pix(int h, int v, bit d);
      @(negedge clk);
      bus.hrow       = 10'(h);
      bus.vcolumn    = 10'(v);
      bus.display    = d;
      bus.frame_tick = 1'b0;
      bus.up = '0; bus.down = '0; bus.left = '0; bus.right = '0;
   endtask

   task automatic idle(int n);
      repeat (n) pix(0, 0, 1'b0);
   endtask

   task automatic tick(logic [1:0] u, logic [1:0] d, logic [1:0] l, logic [1:0] r, int n);
      repeat (n) begin
         @(negedge clk);
         bus.display    = 1'b0;
         bus.frame_tick = 1'b1;
         bus.up = u; bus.down = d; bus.left = l; bus.right = r;
      end
      idle(1);
   endtask

   task automatic scan(int w, int h);
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++)
            pix(x, y, 1'b1);
      idle(3);
   endtask

   initial begin
      rom_fixed[0] = '0; rom_fixed[1] = '0;
      rom_fix_en[0] = 1'b0; rom_fix_en[1] = 1'b0;
      bus.frame_tick = 1'b0; bus.display = 1'b0;
      bus.hrow = '0; bus.vcolumn = '0; bus.background = 12'h0F0;
      bus.up = '0; bus.down = '0; bus.left = '0; bus.right = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // T1: reset state, sprite1 at x=32
      chk("t1_valid", int'(bus.pix_valid), 0);
      chk("t1_coll", int'(bus.collision), 0);
      pix(32, 0, 1'b1);
      idle(1);
      chk("t1_rom_addr", int'(bus.rom_addr), 'h100);
      idle(3);

      // T3: texel ABC at (5,3), latency 2, then background outside
      rom_fix_en[0] = 1'b1; rom_fixed[0] = 12'hABC;
      pix(5, 3, 1'b1);
      pix(100, 100, 1'b1);
      pix(200, 200, 1'b0);
      chk("t3_early_valid", int'(bus.pix_valid), 0);
      chk("t3_rom_addr", int'(bus.rom_addr), 53);
      idle(1);
      chk("t3_color", int'(bus.pix_color), 'hABC);
      chk("t3_valid", int'(bus.pix_valid), 1);
      idle(1);
      chk("t3_bg", int'(bus.pix_color), 'h0F0);
      idle(3);

      // T4: transparent winner over sprite1 shows background
      rom_fixed[0] = 12'h000;
      tick(2'b00, 2'b00, 2'b10, 2'b00, 24);
      pix(10, 2, 1'b1);
      pix(20, 2, 1'b1);
      pix(0, 0, 1'b0);
      idle(1);
      chk("t4_transparent", int'(bus.pix_color), 'h0F0);
      idle(1);
      chk("t4_sprite1", int'(bus.pix_color), 'h22C);
      idle(3);

      // T5: overlap frame -> 11, clean frame -> 00
      rom_fix_en[0] = 1'b0;
      scan(32, 16);
      tick(2'b00, 2'b00, 2'b00, 2'b00, 1);
      chk("t5_coll_overlap", int'(bus.collision), 3);
      tick(2'b00, 2'b00, 2'b00, 2'b10, 24);
      scan(64, 16);
      tick(2'b00, 2'b00, 2'b00, 2'b00, 1);
      chk("t5_coll_clear", int'(bus.collision), 0);

      // T2: clamp right edge, both-asserted hold, bottom clamp, top clamp
      tick(2'b00, 2'b00, 2'b00, 2'b01, 700);
      chk("t2_model_x", mx[0], 624);
      pix(630, 2, 1'b1);
      idle(1);
      chk("t2_addr_edge", int'(bus.rom_addr), 'h026);
      tick(2'b00, 2'b00, 2'b01, 2'b01, 5);
      pix(623, 0, 1'b1);
      pix(624, 0, 1'b1);
      idle(1);
      chk("t2_addr_hold", int'(bus.rom_addr), 'h000);
      tick(2'b01, 2'b10, 2'b00, 2'b00, 500);
      chk("t2_model_y", my[1], 464);
      chk("t2_model_y0", my[0], 0);
      pix(40, 470, 1'b1);
      idle(1);
      chk("t2_addr_bottom", int'(bus.rom_addr), 'h168);

      // T6: reset mid-line
      pix(41, 470, 1'b1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_valid", int'(bus.pix_valid), 0);
      chk("t6_rst_coll", int'(bus.collision), 0);
      chk("t6_rst_addr", int'(bus.rom_addr), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus.hrow = 10'd32; bus.vcolumn = 10'd0; bus.display = 1'b1;
      @(negedge clk);
      chk("t6_valid_1", int'(bus.pix_valid), 0);
      @(negedge clk);
      chk("t6_valid_2", int'(bus.pix_valid), 0);
      chk("t6_addr_s1", int'(bus.rom_addr), 'h100);
      @(negedge clk);
      chk("t6_valid_3", int'(bus.pix_valid), 1);
      idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
